// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests and buffers {pc, instr} for IF/ID.
// Optional FETCH_STATS_EN enables the delivered/dropped statistics counters.
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [63:0] RESET_PC        = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_dropped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned SW = CW + 1;

    logic [63:0]   r_fetch_pc;
    logic [63:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_q_instr [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop_cnt;
    logic [63:0]   r_pf      [MAX_OUTSTANDING];
    logic [PW-1:0] r_pf_rd;
    logic [PW-1:0] r_pf_wr;
    logic [63:0]   r_last_pc;
    logic [31:0]   r_last_instr;

    logic          w_acc;
    logic          w_rsp;
    logic          w_drop;
    logic          w_enq;
    logic          w_deq;
    logic [SW-1:0] w_occ;
    logic [OW-1:0] w_out_next;
    logic [63:0]   w_redirect_target;

    function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Occupancy counts live in-flight requests so every response already owns a queue slot.
    assign w_occ = SW'(r_count) + SW'(r_outstanding) - SW'(r_drop_cnt);

    assign imem_req_valid = !reset && !redirect_valid &&
                            (r_outstanding < OW'(MAX_OUTSTANDING)) &&
                            (w_occ < SW'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;

    assign w_acc             = imem_req_valid && imem_req_ready;
    assign w_rsp             = imem_rsp_valid && (r_outstanding != '0);
    assign w_drop            = w_rsp && (redirect_valid || (r_drop_cnt != '0));
    assign w_enq             = w_rsp && !w_drop;
    assign w_deq             = out_valid && out_ready;
    assign w_out_next        = r_outstanding + OW'(w_acc) - OW'(w_rsp);
    assign w_redirect_target = redirect_pc & ~64'd3;

    assign out_valid = (r_count != '0);
    assign out_pc    = out_valid ? r_q_pc[r_rd_ptr]    : r_last_pc;
    assign out_instr = out_valid ? r_q_instr[r_rd_ptr] : r_last_instr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_pf_rd       <= '0;
            r_pf_wr       <= '0;
            r_last_pc     <= '0;
            r_last_instr  <= '0;
        end else begin
            if (w_acc) begin
                r_pf_wr    <= pf_inc(r_pf_wr);
                r_fetch_pc <= r_fetch_pc + 64'd4;
            end
            if (w_rsp) begin
                r_pf_rd <= pf_inc(r_pf_rd);
            end
            r_outstanding <= w_out_next;
            if (out_valid) begin
                r_last_pc    <= r_q_pc[r_rd_ptr];
                r_last_instr <= r_q_instr[r_rd_ptr];
            end
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_target;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_drop_cnt <= w_out_next;
            end else begin
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - OW'(1);
                end
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_deq) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_pf[r_pf_wr] <= r_fetch_pc;
        end
        if (w_enq) begin
            r_q_pc[r_wr_ptr]    <= r_pf[r_pf_rd];
            r_q_instr[r_wr_ptr] <= imem_rsp_data;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_dropped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_fetched <= '0;
            r_stat_dropped <= '0;
        end else begin
            if (w_deq) begin
                r_stat_fetched <= r_stat_fetched + 32'd1;
            end
            if (w_drop) begin
                r_stat_dropped <= r_stat_dropped + 32'd1;
            end
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_dropped = r_stat_dropped;
`else
    assign stat_fetched = '0;
    assign stat_dropped = '0;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: queue-based reference model, in-order latency memory, directed and random phases.
module tb_fetch_prefetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_OUT  = 2;
    localparam logic [63:0] RST_PC   = 64'd0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] stat_fetched;
    logic [31:0] stat_dropped;

    fetch_prefetch_unit #(
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAX_OUT),
        .RESET_PC(RST_PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instr(out_instr),
        .stat_fetched(stat_fetched),
        .stat_dropped(stat_dropped)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [63:0] pc; bit stale; } req_t;
    typedef struct { logic [63:0] addr; int unsigned due; } mreq_t;

    // reference model
    ent_t        mq[$];
    req_t        infl[$];
    logic [63:0] m_fpc;
    logic [63:0] m_last_pc;
    logic [31:0] m_last_instr;
    int unsigned m_delivered;
    int unsigned m_dropped;

    // memory environment and delivery log
    mreq_t       memq[$];
    logic [63:0] log_pc[$];
    int unsigned log_cyc[$];

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    bit          running = 1'b0;

    int unsigned p_ready = 100, p_oready = 100, p_redir = 0;
    int unsigned lat_min = 1, lat_max = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not reached within cycle budget", nm);
    endtask

    function automatic int unsigned live_inflight();
        int unsigned n = 0;
        foreach (infl[i]) if (!infl[i].stale) n++;
        return n;
    endfunction

    task automatic env_clear();
        mq.delete(); infl.delete(); memq.delete();
        log_pc.delete(); log_cyc.delete();
        m_fpc = RST_PC; m_last_pc = '0; m_last_instr = '0;
        m_delivered = 0; m_dropped = 0;
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    endtask

    // Asserts reset mid-cycle and checks the reset state before any clock edge.
    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        #1;
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", out_instr, 64'd0);
        chk("rst_req_valid", imem_req_valid, 64'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_stat_fetched", stat_fetched, 64'd0);
        chk("rst_stat_dropped", stat_dropped, 64'd0);
        env_clear();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        running = 1'b1;
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
        imem_req_ready = ($urandom_range(99) < p_ready);
        out_ready      = ($urandom_range(99) < p_oready);
        redirect_valid = ($urandom_range(99) < p_redir);
        redirect_pc    = {$urandom, $urandom};
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~memq[0].addr[31:0];
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic model_step(input bit exp_rv);
        req_t r;
        if (mq.size() != 0) begin
            m_last_pc    = mq[0].pc;
            m_last_instr = mq[0].instr;
        end
        if (mq.size() != 0 && out_ready) begin
            void'(mq.pop_front());
            m_delivered++;
        end
        if (imem_rsp_valid && infl.size() != 0) begin
            r = infl.pop_front();
            if (r.stale || redirect_valid) m_dropped++;
            else mq.push_back('{r.pc, imem_rsp_data});
        end
        if (exp_rv && imem_req_ready) begin
            infl.push_back('{m_fpc, 1'b0});
            m_fpc = m_fpc + 64'd4;
        end
        if (redirect_valid) begin
            mq.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            m_fpc = redirect_pc & ~64'd3;
        end
    endtask

    // Compare process: DUT outputs against the model every cycle, then advance model and memory.
    always @(negedge clk) begin
        bit exp_rv;
        if (running && !reset) begin
            exp_rv = !redirect_valid && (infl.size() < MAX_OUT) &&
                     (mq.size() + live_inflight() < DEPTH);
            chk("req_valid", imem_req_valid, exp_rv);
            chk("req_addr", imem_req_addr, m_fpc);
            chk("out_valid", out_valid, mq.size() != 0);
            chk("out_pc", out_pc, (mq.size() != 0) ? mq[0].pc : m_last_pc);
            chk("out_instr", out_instr, (mq.size() != 0) ? mq[0].instr : m_last_instr);
`ifdef FETCH_STATS_EN
            chk("stat_fetched", stat_fetched, m_delivered);
            chk("stat_dropped", stat_dropped, m_dropped);
`else
            chk("stat_fetched", stat_fetched, 64'd0);
            chk("stat_dropped", stat_dropped, 64'd0);
`endif
            if (out_valid && out_ready) begin
                log_pc.push_back(out_pc);
                log_cyc.push_back(cyc);
            end
            if (imem_rsp_valid && memq.size() != 0) void'(memq.pop_front());
            if (imem_req_valid && imem_req_ready)
                memq.push_back('{imem_req_addr, cyc + $urandom_range(lat_max, lat_min)});
            model_step(exp_rv);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0, s0, rc;
        bit hit;
        #2;

        // Zero-wait memory, sink always ready.
        p_ready = 100; p_oready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
        apply_reset();
        for (int k = 0; k < 40 && log_pc.size() < 10; k++) drive();
        chk("A_deliveries", log_pc.size(), 64'd10);
`ifdef FETCH_STATS_EN
        chk("A_stat_fetched10", stat_fetched, 64'd10);
`endif
        for (int i = 0; i < 10 && i < log_pc.size(); i++) chk("A_seq_pc", log_pc[i], 64'(i * 4));
        for (int i = 1; i < 10 && i < log_cyc.size(); i++) chk("A_one_per_cycle", log_cyc[i], log_cyc[i-1] + 1);

        // Sink stalled: queue fills to DEPTH and requests stop.
        p_oready = 0;
        apply_reset();
        repeat (20) drive();
        chk("B_out_valid_full", out_valid, 64'd1);
        chk("B_req_stopped", imem_req_valid, 64'd0);
        chk("B_no_delivery", log_pc.size(), 64'd0);
        p_oready = 100;
        repeat (8) drive();
        for (int i = 0; i < 4; i++) begin
            if (i < log_pc.size()) chk("B_release_pc", log_pc[i], 64'(i * 4));
            else timeout("B_release_pc");
        end
        if (log_cyc.size() >= 4) chk("B_burst", log_cyc[3] - log_cyc[0], 64'd3);

        // Latency 3, redirect while two requests are in flight.
        lat_min = 3; lat_max = 3;
        apply_reset();
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            drive();
            if (infl.size() == 2 && !imem_rsp_valid) hit = 1'b1;
        end
        if (!hit) timeout("C_two_inflight");
        d0 = m_dropped; s0 = stat_dropped;
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        drive();
        log_pc.delete(); log_cyc.delete();
        repeat (12) drive();
        chk("C_model_dropped", m_dropped - d0, 64'd2);
`ifdef FETCH_STATS_EN
        chk("C_stat_dropped", stat_dropped - s0, 64'd2);
`endif
        if (log_pc.size() != 0) chk("C_target_pc", log_pc[0], 64'h100);
        else timeout("C_target_pc");

        // Redirect coinciding with a response and a dequeue.
        lat_min = 1; lat_max = 1;
        apply_reset();
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            drive();
            if (imem_rsp_valid && out_ready && mq.size() != 0 && cyc > 6) hit = 1'b1;
        end
        if (!hit) timeout("D_coincide");
        d0 = m_dropped; s0 = stat_dropped; rc = cyc;
        redirect_valid = 1'b1; redirect_pc = 64'h2000;
        drive();
        chk("D_empty_after", out_valid, 64'd0);
        chk("D_fetch_pc", imem_req_addr, 64'h2000);
        if (log_cyc.size() != 0) chk("D_deq_done", log_cyc[log_cyc.size()-1], rc);
        else timeout("D_deq_done");
        chk("D_model_dropped", m_dropped - d0, 64'd1);
`ifdef FETCH_STATS_EN
        chk("D_stat_dropped", stat_dropped - s0, 64'd1);
`endif

        // Misaligned redirect near the top of the address space, then wrap.
        repeat (4) drive();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        drive();
        log_pc.delete(); log_cyc.delete();
        repeat (10) drive();
        if (log_pc.size() >= 3) begin
            chk("E_pc0", log_pc[0], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("E_pc1_wrap", log_pc[1], 64'h0);
            chk("E_pc2", log_pc[2], 64'h4);
        end else timeout("E_wrap_deliveries");

        // Reset mid-transfer with requests in flight and entries buffered.
        lat_min = 3; lat_max = 3; p_oready = 0;
        apply_reset();
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            drive();
            if (infl.size() == 2 && mq.size() >= 2) hit = 1'b1;
        end
        if (!hit) timeout("F_busy_state");
        chk("F_busy_out_valid", out_valid, 64'd1);
        #1;
        apply_reset();

        // Randomized traffic.
        p_ready = 70; p_oready = 60; p_redir = 4; lat_min = 1; lat_max = 4;
        repeat (3000) drive();
        p_redir = 0;
        repeat (20) drive();

        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
